// File: rtl/ultrasonic_ranger.sv
// Ultrasonic ranging front end: fires the sensor trigger, times the echo pulse in
// clock cycles and turns each result into a debounced obstacle level.
module ultrasonic_ranger #(
  parameter int TRIG_CYCLES   = 10,
  parameter int PERIOD_CYCLES = 50000,
  parameter int WAIT_MAX      = 5000,
  parameter int ECHO_MAX      = 40000,
  parameter int CONFIRM       = 3,
  parameter int W             = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         echo,
  input  logic [W-1:0] near_thresh,
  output logic         trig,
  output logic [W-1:0] distance,
  output logic         dist_valid,
  output logic         timeout,
  output logic         obstacle,
  output logic [2:0]   fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TRIG = 3'd1,
    S_WAIT = 3'd2,
    S_MEAS = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  localparam int PW  = $clog2(PERIOD_CYCLES + 1);
  localparam int CWC = $clog2(CONFIRM + 1);

  localparam logic [W-1:0]   TRIG_LAST   = W'(TRIG_CYCLES - 1);
  localparam logic [W-1:0]   WAIT_LAST   = W'(WAIT_MAX - 1);
  localparam logic [W-1:0]   ECHO_SAT    = W'(ECHO_MAX);
  localparam logic [PW-1:0]  PERIOD_LAST = PW'(PERIOD_CYCLES - 1);
  localparam logic [CWC-1:0] CONFIRM_N   = CWC'(CONFIRM);

  state_t         state_q, state_d;
  logic           sync1_q, echo_s_q;
  logic [W-1:0]   phase_q, phase_d;
  logic [W-1:0]   width_q, width_d;
  logic [PW-1:0]  period_q, period_d;
  logic [W-1:0]   distance_q, distance_d;
  logic           timeout_q, timeout_d;
  logic           valid_q, valid_d;
  logic           obstacle_q, obstacle_d;
  logic [CWC-1:0] disagree_q, disagree_d;
  logic           period_clr;
  logic           near;

  // The echo pin is asynchronous; only the second flop feeds any decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      echo_s_q <= 1'b0;
    end else begin
      sync1_q  <= echo;
      echo_s_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      width_q    <= '0;
      period_q   <= '0;
      distance_q <= '0;
      timeout_q  <= 1'b0;
      valid_q    <= 1'b0;
      obstacle_q <= 1'b0;
      disagree_q <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      width_q    <= width_d;
      period_q   <= period_d;
      distance_q <= distance_d;
      timeout_q  <= timeout_d;
      valid_q    <= valid_d;
      obstacle_q <= obstacle_d;
      disagree_q <= disagree_d;
    end
  end

  // phase_q times both the trigger pulse and the echo wait window.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    width_d    = width_q;
    distance_d = distance_q;
    timeout_d  = timeout_q;
    valid_d    = 1'b0;
    period_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable && !echo_s_q) begin
          state_d    = S_TRIG;
          phase_d    = '0;
          period_clr = 1'b1;
        end
      end
      S_TRIG: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (phase_q == TRIG_LAST) begin
          state_d = S_WAIT;
          phase_d = '0;
        end else begin
          phase_d = phase_q + W'(1);
        end
      end
      S_WAIT: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (echo_s_q) begin
          state_d = S_MEAS;
          width_d = W'(1);
        end else if (phase_q == WAIT_LAST) begin
          state_d    = S_HOLD;
          distance_d = ECHO_SAT;
          timeout_d  = 1'b1;
          valid_d    = 1'b1;
        end else begin
          phase_d = phase_q + W'(1);
        end
      end
      S_MEAS: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (!echo_s_q) begin
          state_d    = S_HOLD;
          distance_d = width_q;
          timeout_d  = 1'b0;
          valid_d    = 1'b1;
        end else if (width_q == ECHO_SAT) begin
          state_d    = S_HOLD;
          distance_d = ECHO_SAT;
          timeout_d  = 1'b1;
          valid_d    = 1'b1;
        end else begin
          width_d = width_q + W'(1);
        end
      end
      S_HOLD: begin
        // A stuck-high echo keeps us here past the period.
        if ((period_q == PERIOD_LAST) && !echo_s_q) begin
          if (enable) begin
            state_d    = S_TRIG;
            phase_d    = '0;
            period_clr = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (period_clr) begin
      period_d = '0;
    end else if (period_q != PERIOD_LAST) begin
      period_d = period_q + PW'(1);
    end else begin
      period_d = period_q;
    end
  end

  // dist_valid is a one-cycle strobe with no back-pressure; consumers must take
  // distance/timeout in that cycle or read the held values later.
  always_comb begin
    obstacle_d = obstacle_q;
    disagree_d = disagree_q;
    near       = !timeout_q && (distance_q < near_thresh);
    if (valid_q) begin
      if (near != obstacle_q) begin
        if (disagree_q + CWC'(1) == CONFIRM_N) begin
          obstacle_d = !obstacle_q;
          disagree_d = '0;
        end else begin
          disagree_d = disagree_q + CWC'(1);
        end
      end else begin
        disagree_d = '0;
      end
    end
  end

  assign trig       = (state_q == S_TRIG);
  assign distance   = distance_q;
  assign dist_valid = valid_q;
  assign timeout    = timeout_q;
  assign obstacle   = obstacle_q;
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger: a sensor-model driver issues echo pulses,
// expected results go into a queue and a monitor checks each dist_valid strobe.
module tb_ultrasonic_ranger;

  localparam int TRIG_C   = 4;
  localparam int PERIOD_C = 200;
  localparam int WAIT_C   = 50;
  localparam int ECHO_C   = 100;
  localparam int BOUND    = 1000;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        echo;
  logic [15:0] near_thresh;
  logic        trig;
  logic [15:0] distance;
  logic        dist_valid;
  logic        timeout;
  logic        obstacle;
  logic [2:0]  fsm_state;

  ultrasonic_ranger #(
    .TRIG_CYCLES  (TRIG_C),
    .PERIOD_CYCLES(PERIOD_C),
    .WAIT_MAX     (WAIT_C),
    .ECHO_MAX     (ECHO_C),
    .CONFIRM      (3),
    .W            (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .echo       (echo),
    .near_thresh(near_thresh),
    .trig       (trig),
    .distance   (distance),
    .dist_valid (dist_valid),
    .timeout    (timeout),
    .obstacle   (obstacle),
    .fsm_state  (fsm_state)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [17:0] exp_q[$];  // {obstacle_after, timeout, distance}
  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;
  int valid_cyc = 0;
  int n_rise = 0, n_fall = 0;
  int rise_cyc = 0, fall_cyc = 0;
  logic trig_d = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event did not occur within %0d cycles (cycle %0d)", name, BOUND, cyc);
  endtask

  // ---------------- monitors ----------------
  initial begin : trig_monitor
    forever begin
      @(negedge clk);
      if (trig && !trig_d) begin
        rise_cyc = cyc;
        n_rise++;
      end
      if (!trig && trig_d) begin
        fall_cyc = cyc;
        n_fall++;
      end
      trig_d = trig;
    end
  end

  initial begin : result_monitor
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && dist_valid) begin
        valid_cyc = cyc;
        n_valid++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_valid: distance=%0d timeout=%0d, no result expected", distance, timeout);
        end else begin
          e = exp_q.pop_front();
          check("distance", distance, e[15:0]);
          check("timeout", timeout, e[16]);
          @(negedge clk);
          check("valid_one_cycle", dist_valid, 0);
          check("obstacle", obstacle, e[17]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_rise(input int nr0);
    int k = 0;
    while (n_rise == nr0 && k < BOUND) begin
      @(negedge clk);
      k++;
    end
    if (n_rise == nr0) bound_fail("trig_rise");
  endtask

  task automatic wait_fall(input int nf0);
    int k = 0;
    while (n_fall == nf0 && k < BOUND) begin
      @(negedge clk);
      k++;
    end
    if (n_fall == nf0) bound_fail("trig_fall");
  endtask

  task automatic wait_valid(input int nv0);
    int k = 0;
    while (n_valid == nv0 && k < BOUND) begin
      @(negedge clk);
      k++;
    end
    if (n_valid == nv0) bound_fail("dist_valid");
  endtask

  // One ranging cycle: wait for the trigger, optionally return an echo of len cycles
  // dly cycles after trig falls (len=0 means no echo), then wait for the result.
  task automatic ranging(input int nr0, input int dly, input int len,
                         input logic [15:0] ed, input logic eto, input logic eob,
                         output int r, output int ef);
    int nf0 = n_fall;
    int nv0 = n_valid;
    exp_q.push_back({eob, eto, ed});
    wait_rise(nr0);
    r = rise_cyc;
    wait_fall(nf0);
    check("trig_width", fall_cyc - rise_cyc, TRIG_C);
    ef = 0;
    if (len > 0) begin
      repeat (dly) @(negedge clk);
      echo = 1'b1;
      repeat (len) @(negedge clk);
      echo = 1'b0;
      ef = cyc;
    end
    wait_valid(nv0);
    if (len == 0) check("timeout_latency", valid_cyc - fall_cyc, WAIT_C);
    else if (!eto) check("valid_latency", valid_cyc - ef, 3);
  endtask

  // ---------------- directed stimulus ----------------
  int d_len[13] = '{20, 20, 40, 20, 20, 20, 40, 40, 0, 30, 20, 20, 29};
  logic d_ob[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin : stimulus
    int rel, r0, r1, r2, r3, r, ef, s_fall, nr0, nf0, nv0, x, k;
    rst_n = 1'b0;
    enable = 1'b1;
    echo = 1'b0;
    near_thresh = 16'd30;
    repeat (5) @(negedge clk);
    check("reset_trig", trig, 0);
    check("reset_valid", dist_valid, 0);
    check("reset_distance", distance, 0);
    check("reset_timeout", timeout, 0);
    check("reset_obstacle", obstacle, 0);
    check("reset_state", fsm_state, 0);

    // cadence and WAIT timeouts
    nr0 = n_rise;
    rst_n = 1'b1;
    rel = cyc;
    ranging(nr0, 0, 0, 16'd100, 1'b1, 1'b0, r0, ef);
    check("first_trig_latency", r0 - rel, 1);
    ranging(n_rise, 0, 0, 16'd100, 1'b1, 1'b0, r1, ef);
    check("trig_period", r1 - r0, PERIOD_C);

    // normal 37-cycle echo
    ranging(n_rise, 20, 37, 16'd37, 1'b0, 1'b0, r2, ef);
    check("trig_period_2", r2 - r1, PERIOD_C);

    // stuck echo saturates and delays the next trigger
    ranging(n_rise, 5, 350, 16'd100, 1'b1, 1'b0, r3, ef);
    s_fall = ef;

    // hysteresis sequence with near_thresh = 30
    for (int i = 0; i < 13; i++) begin
      ranging(n_rise, 10, d_len[i], (d_len[i] == 0) ? 16'd100 : 16'(d_len[i]),
              (d_len[i] == 0), d_ob[i], r, ef);
      if (i == 0) begin
        check("stuck_retrig_after_echo_low", r - s_fall, 3);
        check("stuck_retrig_later_than_period", int'((r - r3) > PERIOD_C), 1);
      end
    end

    // enable dropped mid-measurement
    nr0 = n_rise;
    nf0 = n_fall;
    nv0 = n_valid;
    wait_rise(nr0);
    wait_fall(nf0);
    repeat (10) @(negedge clk);
    echo = 1'b1;
    repeat (10) @(negedge clk);
    check("meas_state_before_drop", fsm_state, 3);
    enable = 1'b0;
    @(negedge clk);
    check("drop_state_idle", fsm_state, 0);
    check("drop_trig_low", trig, 0);
    repeat (5) @(negedge clk);
    enable = 1'b1;
    nr0 = n_rise;
    repeat (20) @(negedge clk);
    check("no_trig_while_echo_high", n_rise - nr0, 0);
    echo = 1'b0;
    x = cyc;
    wait_rise(nr0);
    check("retrig_after_echo_low", rise_cyc - x, 3);
    check("drop_no_valid", n_valid - nv0, 0);
    check("drop_distance_held", distance, 29);
    check("drop_obstacle_held", obstacle, 1);

    // reset in the middle of a measurement
    nf0 = n_fall;
    wait_fall(nf0);
    repeat (5) @(negedge clk);
    echo = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_trig", trig, 0);
    check("midreset_valid", dist_valid, 0);
    check("midreset_distance", distance, 0);
    check("midreset_timeout", timeout, 0);
    check("midreset_obstacle", obstacle, 0);
    check("midreset_state", fsm_state, 0);
    repeat (3) @(negedge clk);
    echo = 1'b0;
    repeat (2) @(negedge clk);
    nr0 = n_rise;
    rst_n = 1'b1;
    rel = cyc;
    ranging(nr0, 10, 25, 16'd25, 1'b0, 1'b0, r, ef);
    check("restart_trig_latency", r - rel, 1);
    ranging(n_rise, 10, 25, 16'd25, 1'b0, 1'b0, r, ef);
    ranging(n_rise, 10, 25, 16'd25, 1'b0, 1'b1, r, ef);

    k = 0;
    while (exp_q.size() != 0 && k < BOUND) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ultrasonic_ranger.md
# ultrasonic_ranger

Sensor-side front end for the obstacle detector: drives the trigger pin of one ultrasonic ranging module, times the returned echo pulse in clock cycles, and turns the measurement into a debounced `obstacle` level. That level is the `sensor_left` / `sensor_right` input the obstacle-detection logic consumes. One instance per side; both instances run from the same clock.

## Interface
- `TRIG_CYCLES`, default 10: trigger pulse width, in cycles.
- `PERIOD_CYCLES`, default 50000: minimum spacing between successive trigger rising edges, in cycles.
- `WAIT_MAX`, default 5000: maximum cycles in WAIT before an echo must appear.
- `ECHO_MAX`, default 40000: echo width saturation value, in cycles.
- `CONFIRM`, default 3: number of consecutive agreeing results needed to change `obstacle`.
- `W`, default 16: counter and distance width. Must satisfy `ECHO_MAX` < 2^W.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  start and continue ranging cycles.
- `echo`  in  1  echo pin from the sensor; asynchronous to `clk`.
- `near_thresh`  in  W  a result strictly below this value counts as near.
- `trig`  out  1  trigger pin to the sensor.
- `distance`  out  W  last echo width, in cycles.
- `dist_valid`  out  1  one-cycle strobe marking a new `distance`.
- `timeout`  out  1  the last result was a timeout or saturation; valid with `distance`.
- `obstacle`  out  1  debounced near indication.

## Operation
- **Echo input:** passes through a 2-flop synchronizer to give `echo_s`. All FSM decisions use `echo_s` only.
- **Reset:** all outputs are 0 and `distance` = 0. FSM is in IDLE; all counters and synchronizer flops are 0.
- **FSM states:** IDLE, TRIG, WAIT, MEAS, HOLD.
- **IDLE:**
  - `enable`=1 and `echo_s`=0 → TRIG.
  - The period counter is cleared on TRIG entry.
- **TRIG:**
  - `trig`=1 for exactly `TRIG_CYCLES` cycles, then WAIT.
  - `trig` is 0 in every other state.
- **WAIT:**
  - `echo_s`=1 → MEAS, with the width counter loaded to 1.
  - After `WAIT_MAX` cycles without an echo → publish a timeout result, then HOLD.
- **MEAS:**
  - `echo_s`=1 → width counter +1.
  - `echo_s`=0 → publish `distance` = width count with `timeout`=0, then HOLD.
  - Width count reaches `ECHO_MAX` while `echo_s`=1 → publish a saturated result, then HOLD.
- **Timeout and saturated results:** `distance`=`ECHO_MAX`, `timeout`=1.
- **Publishing a result:** updates `distance` and `timeout` and pulses `dist_valid` for 1 cycle. `distance` and `timeout` hold until the next result.
- **HOLD:** leaves only when both conditions hold:
  - the period counter is at `PERIOD_CYCLES`-1;
  - `echo_s`=0, so a stuck echo blocks retriggering.
  
  Exit goes to TRIG if `enable`=1, otherwise IDLE.
- **Period counter:** increments every cycle from TRIG entry and saturates at `PERIOD_CYCLES`-1.
- **`enable` dropped in TRIG, WAIT or MEAS:** go to IDLE on the next edge, with `trig`=0. No result is published; `obstacle` and `distance` hold.
- **Obstacle hysteresis:**
  - Each result is classified near if `timeout`=0 and `distance` < `near_thresh`, otherwise far.
  - `near_thresh` is sampled only in the `dist_valid` cycle.
  - A result that disagrees with `obstacle` increments a disagree counter; an agreeing result clears it.
  - When the counter reaches `CONFIRM`, `obstacle` toggles and the counter clears.
- **Reset mid-operation:** immediate return to the reset state, regardless of FSM state or `echo` level.

## Timing
- `trig` rises on the first rising edge at which `rst_n`=1, `enable`=1 and `echo_s`=0, measured from IDLE.
- In steady state, successive `trig` rising edges are exactly `PERIOD_CYCLES` cycles apart, provided HOLD is reached before the period expires and the echo is low by then.
- Measured width equals the number of cycles `echo_s` is high. A clean N-cycle echo pulse gives `distance`=N.
- `dist_valid` rises at the 3rd rising edge after the `echo` pin falls (2 synchronizer edges + 1 FSM edge).
- A WAIT timeout is published `WAIT_MAX` cycles after WAIT entry. A saturation result is published in the cycle after the width count reaches `ECHO_MAX`.
- `obstacle` changes on the edge after the `dist_valid` cycle of the confirming result.

## Test plan
Parameters for all tests: `TRIG_CYCLES`=4, `PERIOD_CYCLES`=200, `WAIT_MAX`=50, `ECHO_MAX`=100, `CONFIRM`=3.

- **Reset and trigger cadence:** reset with `enable`=1, echo held low, then release `rst_n` → outputs 0 during reset; `trig` is high for 4 cycles; trigger rising edges are 200 cycles apart; a timeout result (`distance`=100, `timeout`=1) is published 50 cycles after each trigger ends.
- **Normal echo:** echo goes high 20 cycles after `trig` falls and stays high for 37 cycles → `distance`=37, `timeout`=0, `dist_valid` high for exactly 1 cycle, 3 edges after echo falls.
- **Stuck echo:** echo held high for 350 cycles → `distance`=100 and `timeout`=1 at saturation; the next `trig` does not rise until `echo_s` is low, which is later than 200 cycles after the previous trigger.
- **Hysteresis:** `near_thresh`=30.
  - Result sequence 20, 20, 40, 20, 20, 20 → `obstacle` rises only after the sixth result.
  - Then 40, 40, timeout → `obstacle` falls after the timeout.
  - A result of exactly 30 counts as far.
- **Enable drop:** drop `enable` mid-MEAS → `trig`=0, FSM goes to IDLE, no `dist_valid`, `obstacle` and `distance` unchanged. Re-raise `enable` while echo is still high → no trigger until `echo_s`=0.
- **Reset mid-measurement:** assert `rst_n` low during MEAS → all outputs 0 immediately; after release, operation restarts cleanly from IDLE.
